// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA job sequencer.
// Holds the FSM state enum, response error codes and data width.
package rsa_pkg;

  localparam int DATA_BIT_WIDTH = 2048;

  typedef enum logic [2:0] {
    IDLE,
    O2I,
    O2I_CLR,
    CHECK,
    EXP,
    I2O,
    I2O_CLR,
    RESP
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_RANGE   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_KEY     = 2'b11;

endpackage

// File: rtl/rsa_job_ctrl_stage_timer.sv
// Per-stage wait counter; expired when it reaches TIMEOUT_CYCLES-1.
// Ports: clk, reset, clear (priority), enable, expired.
module stage_timer #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/rsa_job_ctrl.sv
// Sequencer for one RSAEP/RSADP job: O2I, range check, modexp, I2O.
// Ports: req_* job in, o2i_*/exp_*/i2o_* datapath control, rsp_* out.
module rsa_job_ctrl #(
  parameter int DATA_BIT_WIDTH = rsa_pkg::DATA_BIT_WIDTH,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_op,
  input  logic [DATA_BIT_WIDTH-1:0] req_data,
  input  logic [DATA_BIT_WIDTH-1:0] key_n,
  input  logic [DATA_BIT_WIDTH-1:0] key_e,
  input  logic [DATA_BIT_WIDTH-1:0] key_d,
  output logic                      o2i_valid,
  output logic                      o2i_clear,
  output logic [DATA_BIT_WIDTH-1:0] o2i_X,
  input  logic [DATA_BIT_WIDTH-1:0] o2i_x,
  input  logic                      o2i_done,
  output logic                      i2o_valid,
  output logic                      i2o_clear,
  output logic [DATA_BIT_WIDTH-1:0] i2o_x,
  input  logic [DATA_BIT_WIDTH-1:0] i2o_X,
  input  logic                      i2o_done,
  output logic                      exp_start,
  output logic [DATA_BIT_WIDTH-1:0] exp_base,
  output logic [DATA_BIT_WIDTH-1:0] exp_exp,
  output logic [DATA_BIT_WIDTH-1:0] exp_mod,
  input  logic [DATA_BIT_WIDTH-1:0] exp_result,
  input  logic                      exp_done,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_BIT_WIDTH-1:0] rsp_data,
  output logic [1:0]                rsp_err
);

  import rsa_pkg::*;

  localparam int W = DATA_BIT_WIDTH;

  state_t         state;
  logic [W-1:0]   data_q;
  logic [W-1:0]   n_q;
  logic [W-1:0]   e_q;
  logic [W-1:0]   m_q;
  logic [W-1:0]   r_q;
  logic [1:0]     err_q;

  logic           wait_st;
  logic           stage_done;
  logic           tmr_clear;
  logic           tmr_en;
  logic           tmr_expired;

  assign o2i_X    = data_q;
  assign exp_base = m_q;
  assign exp_exp  = e_q;
  assign exp_mod  = n_q;
  assign i2o_x    = r_q;

  assign wait_st = (state == O2I) ||
                   (state == EXP) ||
                   (state == I2O);

  assign stage_done =
    ((state == O2I) && o2i_done) ||
    ((state == EXP) && exp_done) ||
    ((state == I2O) && i2o_done);

  // Clearing on the awaited done restarts the count
  // for the back-to-back EXP -> I2O wait.
  assign tmr_clear = !wait_st || stage_done;
  assign tmr_en    = wait_st;

  stage_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .expired(tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= ERR_OK;
      rsp_data  <= '0;
      o2i_valid <= 1'b0;
      o2i_clear <= 1'b0;
      i2o_valid <= 1'b0;
      i2o_clear <= 1'b0;
      exp_start <= 1'b0;
      data_q    <= '0;
      n_q       <= '0;
      e_q       <= '0;
      m_q       <= '0;
      r_q       <= '0;
      err_q     <= ERR_OK;
    end else begin
      o2i_clear <= 1'b0;
      i2o_clear <= 1'b0;
      exp_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            data_q    <= req_data;
            n_q       <= key_n;
            e_q       <= req_op ? key_d : key_e;
            err_q     <= ERR_OK;
            req_ready <= 1'b0;
            o2i_valid <= 1'b1;
            state     <= O2I;
          end
        end
        O2I: begin
          if (o2i_done) begin
            m_q       <= o2i_x;
            o2i_valid <= 1'b0;
            o2i_clear <= 1'b1;
            state     <= O2I_CLR;
          end else if (tmr_expired) begin
            o2i_valid <= 1'b0;
            o2i_clear <= 1'b1;
            err_q     <= ERR_TIMEOUT;
            state     <= O2I_CLR;
          end
        end
        O2I_CLR: begin
          if (err_q == ERR_TIMEOUT) begin
            rsp_valid <= 1'b1;
            rsp_err   <= ERR_TIMEOUT;
            rsp_data  <= '0;
            state     <= RESP;
          end else begin
            state <= CHECK;
          end
        end
        CHECK: begin
          if (n_q == '0) begin
            rsp_valid <= 1'b1;
            rsp_err   <= ERR_KEY;
            rsp_data  <= '0;
            state     <= RESP;
          end else if (m_q >= n_q) begin
            rsp_valid <= 1'b1;
            rsp_err   <= ERR_RANGE;
            rsp_data  <= '0;
            state     <= RESP;
          end else begin
            exp_start <= 1'b1;
            state     <= EXP;
          end
        end
        EXP: begin
          if (exp_done) begin
            r_q       <= exp_result;
            i2o_valid <= 1'b1;
            state     <= I2O;
          end else if (tmr_expired) begin
            rsp_valid <= 1'b1;
            rsp_err   <= ERR_TIMEOUT;
            rsp_data  <= '0;
            state     <= RESP;
          end
        end
        I2O: begin
          if (i2o_done) begin
            rsp_data  <= i2o_X;
            i2o_valid <= 1'b0;
            i2o_clear <= 1'b1;
            state     <= I2O_CLR;
          end else if (tmr_expired) begin
            i2o_valid <= 1'b0;
            i2o_clear <= 1'b1;
            err_q     <= ERR_TIMEOUT;
            state     <= I2O_CLR;
          end
        end
        I2O_CLR: begin
          rsp_valid <= 1'b1;
          rsp_err   <= err_q;
          if (err_q != ERR_OK) begin
            rsp_data <= '0;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_job_ctrl.sv
// Bench for rsa_job_ctrl with converter and modexp models.
// Directed cases plus randomized jobs against a modexp reference.
module tb_rsa_job_ctrl;

  localparam int W  = 64;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic         req_op;
  logic [W-1:0] req_data;
  logic [W-1:0] key_n;
  logic [W-1:0] key_e;
  logic [W-1:0] key_d;
  logic         o2i_valid;
  logic         o2i_clear;
  logic [W-1:0] o2i_X;
  logic [W-1:0] o2i_x;
  logic         o2i_done;
  logic         i2o_valid;
  logic         i2o_clear;
  logic [W-1:0] i2o_x;
  logic [W-1:0] i2o_X;
  logic         i2o_done;
  logic         exp_start;
  logic [W-1:0] exp_base;
  logic [W-1:0] exp_exp;
  logic [W-1:0] exp_mod;
  logic [W-1:0] exp_result;
  logic         exp_done;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic [1:0]   rsp_err;

  int n_assert = 0;
  int n_fail   = 0;

  int o2i_lat = 2;
  int i2o_lat = 2;
  int exp_lat = 3;
  bit exp_hang = 1'b0;

  int n_o2i_clr = 0;
  int n_i2o_clr = 0;
  int n_start   = 0;

  always #5 clk = ~clk;

  rsa_job_ctrl #(
    .DATA_BIT_WIDTH(W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .key_n     (key_n),
    .key_e     (key_e),
    .key_d     (key_d),
    .o2i_valid (o2i_valid),
    .o2i_clear (o2i_clear),
    .o2i_X     (o2i_X),
    .o2i_x     (o2i_x),
    .o2i_done  (o2i_done),
    .i2o_valid (i2o_valid),
    .i2o_clear (i2o_clear),
    .i2o_x     (i2o_x),
    .i2o_X     (i2o_X),
    .i2o_done  (i2o_done),
    .exp_start (exp_start),
    .exp_base  (exp_base),
    .exp_exp   (exp_exp),
    .exp_mod   (exp_mod),
    .exp_result(exp_result),
    .exp_done  (exp_done),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  function automatic logic [W-1:0] modexp(
    input logic [W-1:0] b,
    input logic [W-1:0] e,
    input logic [W-1:0] m
  );
    logic [127:0] r;
    logic [127:0] x;
    if (m == '0) return '0;
    r = 128'(1) % 128'(m);
    x = 128'(b) % 128'(m);
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = (r * x) % 128'(m);
      x = (x * x) % 128'(m);
    end
    return r[W-1:0];
  endfunction

  // Octet-to-integer model: identity, sticky done.
  int o2i_cnt;
  always @(posedge clk) begin
    if (reset || o2i_clear) begin
      o2i_done <= 1'b0;
      o2i_cnt  <= 0;
    end else if (o2i_valid && !o2i_done) begin
      if (o2i_cnt >= o2i_lat) begin
        o2i_done <= 1'b1;
        o2i_x    <= o2i_X;
      end else begin
        o2i_cnt <= o2i_cnt + 1;
      end
    end
  end

  int i2o_cnt;
  always @(posedge clk) begin
    if (reset || i2o_clear) begin
      i2o_done <= 1'b0;
      i2o_cnt  <= 0;
    end else if (i2o_valid && !i2o_done) begin
      if (i2o_cnt >= i2o_lat) begin
        i2o_done <= 1'b1;
        i2o_X    <= i2o_x;
      end else begin
        i2o_cnt <= i2o_cnt + 1;
      end
    end
  end

  // Modexp engine model: one-cycle done pulse.
  bit           e_busy;
  int           e_cnt;
  logic [W-1:0] e_res;
  always @(posedge clk) begin
    exp_done <= 1'b0;
    if (reset) begin
      e_busy <= 1'b0;
    end else if (exp_start) begin
      e_busy <= 1'b1;
      e_cnt  <= 0;
      e_res  <= modexp(exp_base, exp_exp, exp_mod);
    end else if (e_busy && !exp_hang) begin
      if (e_cnt >= exp_lat) begin
        exp_done   <= 1'b1;
        exp_result <= e_res;
        e_busy     <= 1'b0;
      end else begin
        e_cnt <= e_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (o2i_clear) n_o2i_clr++;
    if (i2o_clear) n_i2o_clr++;
    if (exp_start) n_start++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(
    input string        tag,
    input logic [W-1:0] obs,
    input logic [W-1:0] exp
  );
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic send(
    input logic         op,
    input logic [W-1:0] data,
    input logic [W-1:0] n,
    input logic [W-1:0] e,
    input logic [W-1:0] d
  );
    int k;
    @(negedge clk);
    k = 0;
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) check("req_ready_wait", 64'(req_ready), 1);
    req_valid = 1'b1;
    req_op    = op;
    req_data  = data;
    key_n     = n;
    key_e     = e;
    key_d     = d;
    @(negedge clk);
    req_valid = 1'b0;
    req_data  = {$urandom, $urandom};
    key_n     = {$urandom, $urandom};
    key_e     = {$urandom, $urandom};
    key_d     = {$urandom, $urandom};
  endtask

  task automatic wait_rsp(output int cycles);
    cycles = 0;
    while (!rsp_valid && cycles < 300) begin
      @(negedge clk);
      cycles++;
    end
    if (cycles >= 300) check("rsp_wait", 64'(rsp_valid), 1);
  endtask

  task automatic finish_rsp(input int hold);
    repeat (hold) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_drop", 64'(rsp_valid), 0);
    check("idle_ready", 64'(req_ready), 1);
  endtask

  task automatic run_job(
    input logic         op,
    input logic [W-1:0] data,
    input logic [W-1:0] n,
    input logic [W-1:0] e,
    input logic [W-1:0] d,
    input int           hold,
    input bit           tmo
  );
    logic [W-1:0] xe;
    logic [W-1:0] xd;
    logic [1:0]   xr;
    int           c0, i0, s0, cyc;
    xe = op ? d : e;
    if (tmo) begin
      xr = 2'b10; xd = '0;
    end else if (n == '0) begin
      xr = 2'b11; xd = '0;
    end else if (data >= n) begin
      xr = 2'b01; xd = '0;
    end else begin
      xr = 2'b00; xd = modexp(data, xe, n);
    end
    c0 = n_o2i_clr; i0 = n_i2o_clr; s0 = n_start;
    rsp_ready = (hold == 0);
    send(op, data, n, e, d);
    wait_rsp(cyc);
    check("job_data", rsp_data, xd);
    check("job_err", 64'(rsp_err), 64'(xr));
    check("job_o2i_clr", 64'(n_o2i_clr - c0), 1);
    if (xr == 2'b00) begin
      check("job_i2o_clr", 64'(n_i2o_clr - i0), 1);
      check("job_start", 64'(n_start - s0), 1);
      check("job_exp_exp", exp_exp, xe);
      check("job_exp_mod", exp_mod, n);
    end else if (xr != 2'b10) begin
      check("err_no_start", 64'(n_start - s0), 0);
    end
    finish_rsp(hold);
  endtask

  initial begin
    int k;
    int c;
    int s0;
    int i0;
    bit seen;
    logic [W-1:0] d0;
    logic [1:0]   e0;
    logic [W-1:0] n;
    logic [W-1:0] m;

    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 1'b0;
    req_data  = '0;
    key_n     = '0;
    key_e     = '0;
    key_d     = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 1);
    check("rst_rsp_valid", 64'(rsp_valid), 0);
    check("rst_rsp_err", 64'(rsp_err), 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_o2i_valid", 64'(o2i_valid), 0);
    check("rst_i2o_valid", 64'(i2o_valid), 0);
    check("rst_exp_start", 64'(exp_start), 0);
    check("rst_clears", 64'({o2i_clear, i2o_clear}), 0);
    reset = 1'b0;

    run_job(1'b0, 65, 3233, 17, 2753, 0, 1'b0);
    check("pub_data", rsp_data, 2790);
    check("pub_base", exp_base, 65);
    check("pub_exp", exp_exp, 17);
    check("pub_mod", exp_mod, 3233);

    run_job(1'b1, 2790, 3233, 17, 2753, 0, 1'b0);
    check("priv_data", rsp_data, 65);

    // Range error: response one cycle after CHECK.
    s0 = n_start;
    rsp_ready = 1'b1;
    send(1'b0, 3233, 3233, 17, 2753);
    k = 0;
    while (!o2i_clear && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("range_clr_seen", 64'(o2i_clear), 1);
    @(negedge clk);
    check("range_check_cyc", 64'(rsp_valid), 0);
    @(negedge clk);
    check("range_valid", 64'(rsp_valid), 1);
    check("range_err", 64'(rsp_err), 1);
    check("range_data", rsp_data, 0);
    finish_rsp(0);
    check("range_no_start", 64'(n_start - s0), 0);

    run_job(1'b0, 0, 0, 17, 2753, 0, 1'b0);

    // Modexp never finishes.
    exp_hang = 1'b1;
    i0 = n_i2o_clr;
    send(1'b0, 65, 3233, 17, 2753);
    k = 0;
    while (!exp_start && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("tmo_start_seen", 64'(exp_start), 1);
    c = 0;
    while (!rsp_valid && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("tmo_latency", 64'(c), TO);
    check("tmo_err", 64'(rsp_err), 2);
    check("tmo_data", rsp_data, 0);
    check("tmo_no_i2o", 64'(n_i2o_clr - i0), 0);
    finish_rsp(0);
    exp_hang = 1'b0;

    // Converter stalls past the timeout.
    o2i_lat = 40;
    run_job(1'b0, 65, 3233, 17, 2753, 0, 1'b1);
    o2i_lat = 2;

    // Backpressure: response held, new requests ignored.
    rsp_ready = 1'b0;
    send(1'b0, 65, 3233, 17, 2753);
    wait_rsp(c);
    d0 = rsp_data;
    e0 = rsp_err;
    check("bp_data", d0, 2790);
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1;
      @(negedge clk);
      check("bp_valid", 64'(rsp_valid), 1);
      check("bp_hold_data", rsp_data, d0);
      check("bp_hold_err", 64'(rsp_err), 64'(e0));
      check("bp_req_ready", 64'(req_ready), 0);
    end
    req_valid = 1'b0;
    finish_rsp(0);

    // Reset during EXP abandons the job.
    exp_hang = 1'b1;
    send(1'b0, 65, 3233, 17, 2753);
    k = 0;
    while (!exp_start && k < 100) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_exp_ready", 64'(req_ready), 1);
    check("rst_exp_rsp", 64'(rsp_valid), 0);
    exp_hang = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("rst_no_rsp", 64'(seen), 0);

    // Randomized jobs.
    for (int j = 0; j < 24; j++) begin
      o2i_lat = $urandom_range(0, 6);
      i2o_lat = $urandom_range(0, 6);
      exp_lat = $urandom_range(0, 8);
      n = {$urandom, $urandom};
      if (j % 6 == 5) n = '0;
      m = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0 && n != '0) m = m % n;
      run_job(1'($urandom), m, n,
              {$urandom, $urandom}, {$urandom, $urandom},
              $urandom_range(0, 3), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
